cp_inserter: RTL and testbench

Cyclic-prefix insertion stage directly downstream of the 8-point IFFT in the OFDM transmitter. It accepts one time-domain symbol of N complex samples per Avalon-ST packet (sop/eop framed, ready latency 0) and emits N+CP_LEN samples per packet: the last CP_LEN samples first, then all N samples in order. Two ping-pong symbol banks let the IFFT deliver the next symbol while the current one is streamed out to the DAC/upconversion path.

---
 rtl/ofdm_pkg.sv | 25 ++
 rtl/cp_bank_ram.sv | 37 +++
 rtl/cp_inserter.sv | 208 ++++++++++++++++++++
 tb/tb_cp_inserter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ofdm_pkg
// Description : Shared OFDM transmitter constants, complex sample type and
//               IFFT error codes.
// Revision    : 1.0 - initial release
// ============================================================================
package ofdm_pkg;

    localparam int N_FFT    = 8;
    localparam int CP_LEN   = 2;
    localparam int SAMPLE_W = 8;

    typedef struct packed {
        logic [SAMPLE_W-1:0] re;
        logic [SAMPLE_W-1:0] im;
    } cplx_t;

    localparam logic [1:0] ERR_NONE      = 2'b00;
    localparam logic [1:0] ERR_OVERFLOW  = 2'b01;
    localparam logic [1:0] ERR_UNDERFLOW = 2'b10;
    localparam logic [1:0] ERR_OTHER     = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cp_bank_ram.sv
`default_nettype none
// ============================================================================
// Module      : cp_bank_ram
// Description : Two banks of N complex samples; one synchronous write port,
//               one combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module cp_bank_ram #(
    parameter int DW = ofdm_pkg::SAMPLE_W,
    parameter int N  = ofdm_pkg::N_FFT,
    parameter int IW = $clog2(ofdm_pkg::N_FFT)
) (
    input  logic            clk,
    input  logic            we,
    input  logic            wbank,
    input  logic [IW-1:0]   widx,
    input  logic [2*DW-1:0] wdata,
    input  logic            rbank,
    input  logic [IW-1:0]   ridx,
    output logic [2*DW-1:0] rdata
);
    import ofdm_pkg::*;

    // Bank select is the address MSB; N is a power of two so this is dense.
    logic [2*DW-1:0] r_mem [2*N];

    // Store one sample per accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[{wbank, widx}] <= wdata;
        end
    end

    assign rdata = r_mem[{rbank, ridx}];

endmodule
`default_nettype wire

// File: rtl/cp_inserter.sv
`default_nettype none
// ============================================================================
// Module      : cp_inserter
// Description : Cyclic-prefix insertion with ping-pong symbol banks. Each
//               N-sample input packet is replayed as its last CP_LEN samples
//               followed by all N samples.
// Revision    : 1.0 - initial release
// ============================================================================
module cp_inserter #(
    parameter int DW     = ofdm_pkg::SAMPLE_W,
    parameter int N      = ofdm_pkg::N_FFT,
    parameter int CP_LEN = ofdm_pkg::CP_LEN
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sink_valid,
    output logic          sink_ready,
    input  logic          sink_sop,
    input  logic          sink_eop,
    input  logic [1:0]    sink_error,
    input  logic [DW-1:0] sink_real,
    input  logic [DW-1:0] sink_imag,
    output logic          source_valid,
    input  logic          source_ready,
    output logic          source_sop,
    output logic          source_eop,
    output logic [DW-1:0] source_real,
    output logic [DW-1:0] source_imag,
    output logic          sym_drop
);
    import ofdm_pkg::*;

    localparam int              c_IW       = $clog2(N);
    localparam logic [c_IW-1:0] c_LAST     = c_IW'(N - 1);
    localparam logic [c_IW-1:0] c_CP_START = c_IW'(N - CP_LEN);
    localparam logic [c_IW-1:0] c_ONE      = c_IW'(1);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_FILL = 1'b1;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_CP   = 2'd1;
    localparam logic [1:0] R_BODY = 2'd2;

    // write side
    logic [0:0]      r_wstate, w_wstate_nx;
    logic [c_IW-1:0] r_widx, w_widx_nx, w_wr_idx;
    logic            r_wbank;
    logic            r_err, w_err_nx, w_err_acc;
    logic            r_drop, w_drop;
    logic            w_sink_beat, w_we, w_commit;
    // read side
    logic [1:0]      r_rstate, w_rstate_nx;
    logic [c_IW-1:0] r_ridx, w_ridx_nx;
    logic            r_rbank;
    logic            w_src_beat, w_release;
    // shared
    logic [1:0]      r_full;
    logic [2*DW-1:0] w_rdata;

    assign sink_ready  = ~reset & ~r_full[r_wbank];
    assign w_sink_beat = sink_valid & sink_ready;

    // Write FSM: place samples, validate framing, commit or drop the symbol.
    always_comb begin
        w_wstate_nx = r_wstate;
        w_widx_nx   = r_widx;
        w_err_nx    = r_err;
        w_we        = 1'b0;
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        // A sop always restarts the symbol, discarding any earlier error.
        w_wr_idx    = sink_sop ? '0 : r_widx;
        w_err_acc   = (sink_sop ? 1'b0 : r_err) | (sink_error != ERR_NONE);
        if (w_sink_beat) begin
            if ((r_wstate == W_IDLE) && !sink_sop) begin
                w_drop = 1'b1;
            end else begin
                w_we = 1'b1;
                if ((r_wstate == W_FILL) && sink_sop) begin
                    w_drop = 1'b1;
                end
                if (sink_eop || (w_wr_idx == c_LAST)) begin
                    w_wstate_nx = W_IDLE;
                    w_widx_nx   = '0;
                    w_err_nx    = 1'b0;
                    if (sink_eop && (w_wr_idx == c_LAST) && !w_err_acc) begin
                        w_commit = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end else begin
                    w_wstate_nx = W_FILL;
                    w_widx_nx   = w_wr_idx + c_ONE;
                    w_err_nx    = w_err_acc;
                end
            end
        end
    end

    // Write FSM state, bank pointer and drop pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_widx   <= '0;
            r_err    <= 1'b0;
            r_wbank  <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_wstate <= w_wstate_nx;
            r_widx   <= w_widx_nx;
            r_err    <= w_err_nx;
            r_drop   <= w_drop;
            if (w_commit) begin
                r_wbank <= ~r_wbank;
            end
        end
    end

    // Bank occupancy; a commit and a release never target the same bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 2'b00;
        end else begin
            r_full[0] <= (r_full[0] | (w_commit & ~r_wbank)) & ~(w_release & ~r_rbank);
            r_full[1] <= (r_full[1] | (w_commit &  r_wbank)) & ~(w_release &  r_rbank);
        end
    end

    // Read FSM: prefix from index N-CP_LEN, then the body from index 0.
    always_comb begin
        w_rstate_nx = r_rstate;
        w_ridx_nx   = r_ridx;
        w_release   = 1'b0;
        w_src_beat  = (r_rstate != R_IDLE) & source_ready;
        case (r_rstate)
            R_IDLE: begin
                if (r_full[r_rbank]) begin
                    w_rstate_nx = R_CP;
                    w_ridx_nx   = c_CP_START;
                end
            end
            R_CP: begin
                if (w_src_beat) begin
                    if (r_ridx == c_LAST) begin
                        w_rstate_nx = R_BODY;
                        w_ridx_nx   = '0;
                    end else begin
                        w_ridx_nx = r_ridx + c_ONE;
                    end
                end
            end
            R_BODY: begin
                if (w_src_beat) begin
                    if (r_ridx == c_LAST) begin
                        w_release   = 1'b1;
                        w_ridx_nx   = c_CP_START;
                        w_rstate_nx = r_full[~r_rbank] ? R_CP : R_IDLE;
                    end else begin
                        w_ridx_nx = r_ridx + c_ONE;
                    end
                end
            end
            default: begin
                w_rstate_nx = R_IDLE;
            end
        endcase
    end

    // Read FSM state and bank pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rstate <= R_IDLE;
            r_ridx   <= '0;
            r_rbank  <= 1'b0;
        end else begin
            r_rstate <= w_rstate_nx;
            r_ridx   <= w_ridx_nx;
            if (w_release) begin
                r_rbank <= ~r_rbank;
            end
        end
    end

    cp_bank_ram #(
        .DW (DW),
        .N  (N),
        .IW (c_IW)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .wbank (r_wbank),
        .widx  (w_wr_idx),
        .wdata ({sink_real, sink_imag}),
        .rbank (r_rbank),
        .ridx  (r_ridx),
        .rdata (w_rdata)
    );

    assign source_valid = ~reset & (r_rstate != R_IDLE);
    assign source_sop   = source_valid & (r_rstate == R_CP) & (r_ridx == c_CP_START);
    assign source_eop   = source_valid & (r_rstate == R_BODY) & (r_ridx == c_LAST);
    assign source_real  = source_valid ? w_rdata[2*DW-1:DW] : '0;
    assign source_imag  = source_valid ? w_rdata[DW-1:0]    : '0;
    assign sym_drop     = ~reset & r_drop;

endmodule
`default_nettype wire

// File: tb/tb_cp_inserter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp_inserter
// Description : Directed, table-driven bench for cp_inserter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp_inserter;
    import ofdm_pkg::*;

    logic       clk;
    logic       reset;
    logic       sink_valid, sink_ready, sink_sop, sink_eop;
    logic [1:0] sink_error;
    logic [7:0] sink_real, sink_imag;
    logic       source_valid, source_ready, source_sop, source_eop;
    logic [7:0] source_real, source_imag;
    logic       sym_drop;

    cp_inserter dut (
        .clk          (clk),
        .reset        (reset),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_error   (sink_error),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .sym_drop     (sym_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Symbol k-th sample: real = re0 + k, imag = im0 - k; expected packet listed by hand.
    typedef struct packed {
        logic [7:0]      re0;
        logic [7:0]      im0;
        logic [0:9][7:0] exp_re;
        logic [0:9][7:0] exp_im;
    } vec_t;

    typedef struct packed {
        logic [7:0]  re;
        logic [7:0]  im;
        logic        sop;
        logic        eop;
        logic [31:0] cyc;
    } beat_t;

    vec_t        vecs [3];
    beat_t       out_q [$];
    int          total = 0;
    int          bad = 0;
    int          drop_cnt = 0;
    logic [31:0] cyc = 0;
    logic [31:0] last_cyc = 0;
    bit          have_last = 0;
    bit          stall_done = 0;
    logic        p_valid = 0, p_ready = 0, p_sop = 0, p_eop = 0;
    logic [7:0]  p_re = 0, p_im = 0;
    bit [0:3]    stall_pat = 4'b1001;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: hold-while-stalled, zero-when-idle, beat capture, drop count.
    always @(negedge clk) begin
        if (p_valid && !p_ready)
            chk("hold_stable", {source_valid, source_sop, source_eop, source_real, source_imag},
                {1'b1, p_sop, p_eop, p_re, p_im});
        if (!source_valid)
            chk("idle_data_zero", {source_sop, source_eop, source_real, source_imag}, 0);
        if (source_valid && source_ready)
            out_q.push_back({source_real, source_imag, source_sop, source_eop, cyc});
        if (sym_drop) drop_cnt++;
        p_valid = source_valid; p_ready = source_ready;
        p_sop = source_sop; p_eop = source_eop;
        p_re = source_real; p_im = source_imag;
    end

    task automatic send_beat(input logic sop, input logic eop, input logic [1:0] err,
                             input logic [7:0] re, input logic [7:0] im);
        bit acc = 0;
        int n = 0;
        sink_valid = 1'b1; sink_sop = sop; sink_eop = eop;
        sink_error = err; sink_real = re; sink_imag = im;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = sink_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("sink_accept_timeout", 0, 1);
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        sink_error = ERR_NONE; sink_real = '0; sink_imag = '0;
    endtask

    // nb beats; sop on beat 0 and on sop2_at; eop on the last beat if has_eop; error on err_at.
    task automatic send_sym(input int r, input int nb, input bit has_eop,
                            input int sop2_at, input int err_at);
        for (int k = 0; k < nb; k++)
            send_beat((k == 0) || (k == sop2_at), has_eop && (k == nb - 1),
                      (k == err_at) ? ERR_OVERFLOW : ERR_NONE,
                      vecs[r].re0 + 8'(k), vecs[r].im0 - 8'(k));
    endtask

    task automatic check_latency();
        @(negedge clk);
        chk("latency_edge1_valid", source_valid, 0);
        @(negedge clk);
        chk("latency_edge2_valid_sop", {source_valid, source_sop}, 2'b11);
    endtask

    task automatic check_pkt(input int r, input bit gap_chk);
        beat_t b;
        for (int j = 0; j < 10; j++) begin
            int n = 0;
            while (out_q.size() == 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (out_q.size() == 0) begin
                chk("packet_timeout", 0, 1);
                return;
            end
            b = out_q.pop_front();
            chk($sformatf("pkt%0d_beat%0d", r, j), {b.re, b.im, b.sop, b.eop},
                {vecs[r].exp_re[j], vecs[r].exp_im[j], (j == 0), (j == 9)});
            if (gap_chk && have_last) chk("contiguous_beat", b.cyc, last_cyc + 1);
            last_cyc  = b.cyc;
            have_last = 1;
        end
    endtask

    initial begin
        vecs[0].re0 = 8'h01; vecs[0].im0 = 8'hFF;
        vecs[0].exp_re = {8'h07, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        vecs[0].exp_im = {8'hF9, 8'hF8, 8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA, 8'hF9, 8'hF8};
        vecs[1].re0 = 8'h80; vecs[1].im0 = 8'h7F;
        vecs[1].exp_re = {8'h86, 8'h87, 8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
        vecs[1].exp_im = {8'h79, 8'h78, 8'h7F, 8'h7E, 8'h7D, 8'h7C, 8'h7B, 8'h7A, 8'h79, 8'h78};
        vecs[2].re0 = 8'hFC; vecs[2].im0 = 8'h10;
        vecs[2].exp_re = {8'h02, 8'h03, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
        vecs[2].exp_im = {8'h0A, 8'h09, 8'h10, 8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h09};

        reset = 1'b1; source_ready = 1'b1;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
        sink_error = ERR_NONE; sink_real = '0; sink_imag = '0;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("in_reset_outputs", {sink_ready, source_valid, source_sop, source_eop, sym_drop}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("after_reset_outputs",
            {sink_ready, source_valid, source_sop, source_eop, sym_drop, source_real, source_imag},
            {1'b1, 4'b0, 16'h0});

        // Single symbol with latency
        @(posedge clk); #1;
        send_sym(0, 8, 1, -1, -1);
        check_latency();
        check_pkt(0, 0);

        // Three back-to-back symbols, output must be gap-free
        repeat (5) @(posedge clk);
        #1;
        have_last = 0;
        fork
            for (int r = 0; r < 3; r++) send_sym(r, 8, 1, -1, -1);
            for (int r = 0; r < 3; r++) check_pkt(r, 1);
        join

        // Downstream stalls with pattern 1,0,0,1
        repeat (5) @(posedge clk);
        #1;
        stall_done = 0;
        fork
            begin
                send_sym(1, 8, 1, -1, -1);
                check_pkt(1, 0);
                stall_done = 1;
            end
            for (int i = 0; i < 400 && !stall_done; i++) begin
                @(posedge clk);
                #1;
                source_ready = stall_pat[i % 4];
            end
        join
        source_ready = 1'b1;

        // Malformed: early eop, restart by sop, error beat
        repeat (5) @(posedge clk);
        #1;
        drop_cnt = 0;
        send_sym(2, 5, 1, -1, -1);
        send_sym(2, 3, 0, -1, -1);
        send_sym(1, 8, 1, -1, 2);
        repeat (15) @(posedge clk);
        #1;
        chk("malformed_drop_count", drop_cnt, 3);
        chk("malformed_no_output", out_q.size(), 0);
        send_sym(0, 8, 1, -1, -1);
        check_latency();
        check_pkt(0, 0);

        // Both banks full with downstream stalled
        repeat (5) @(posedge clk);
        #1;
        source_ready = 1'b0;
        send_sym(0, 8, 1, -1, -1);
        send_sym(1, 8, 1, -1, -1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("full_sink_ready_low", sink_ready, 0);
        end
        @(posedge clk); #1;
        source_ready = 1'b1;
        begin
            bit seen = 0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (source_valid && source_eop) seen = 1;
            end
            chk("full_first_eop_seen", seen, 1);
            chk("full_ready_at_eop", sink_ready, 0);
            @(negedge clk);
            chk("full_ready_after_eop", sink_ready, 1);
        end
        check_pkt(0, 0);
        check_pkt(1, 0);

        // Reset mid-output
        repeat (5) @(posedge clk);
        #1;
        send_sym(1, 8, 1, -1, -1);
        begin
            int n = 0;
            while (out_q.size() < 3 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("midreset_output_started", out_q.size() >= 3, 1);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_in_reset", {sink_ready, source_valid, source_sop, source_eop, sym_drop}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        out_q.delete();
        @(negedge clk);
        chk("midreset_after",
            {sink_ready, source_valid, source_sop, source_eop, sym_drop, source_real, source_imag},
            {1'b1, 4'b0, 16'h0});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midreset_no_residual", {source_valid, source_sop, source_eop}, 0);
        end
        @(posedge clk); #1;
        send_sym(2, 8, 1, -1, -1);
        check_latency();
        check_pkt(2, 0);

        repeat (5) @(posedge clk);
        chk("no_stray_drops", drop_cnt, 3);
        chk("queue_drained", out_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
